// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the slice counter: clog2(n), never below one bit.
  function automatic int cnt_width(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB
// so the top can derive signed overflow on the final slice.
module chunked_addsub_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};
  assign o_s     = w_full[CHUNK-1:0];
  assign o_co    = w_full[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum bit.
  assign o_c_msb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock with a registered
// carry between slices, valid/ready handshakes on both sides.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cs;
  logic             w_co;
  logic             w_c_msb;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

  assign w_ca   = r_opa[r_cnt*CHUNK +: CHUNK];
  assign w_cb   = r_opb[r_cnt*CHUNK +: CHUNK];
  assign w_last = (r_cnt == LAST);

  chunked_addsub_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .i_a     (w_ca),
    .i_b     (w_cb),
    .i_ci    (r_carry),
    .o_s     (w_cs),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode; handshakes depend only on the state register.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_next = ST_RUN;
        else            w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
        else        w_next = ST_RUN;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (i_out_ready) w_next = ST_IDLE;
        else             w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture and slice-by-slice accumulation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_opa   <= {WIDTH{1'b0}};
      r_opb   <= {WIDTH{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            // Subtract is a + ~b + ~borrow.
            r_opa   <= i_a;
            r_opb   <= i_b ^ {WIDTH{i_sub}};
            r_carry <= i_cin ^ i_sub;
            r_sum   <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          r_sum[r_cnt*CHUNK +: CHUNK] <= w_cs;
          r_carry <= w_co;
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_c_msb ^ w_co;
            r_cnt  <= {CW{1'b0}};
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three configurations (16/4, 32/8, 16/16) checked
// against an integer-arithmetic reference model.
module tb_chunked_addsub;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_v;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic [2:0]  rdy;
  logic [2:0]  ov_v;
  logic [2:0]  co_v;
  logic [2:0]  of_v;
  logic [15:0] sum0;
  logic [31:0] sum1;
  logic [15:0] sum2;

  int          sel;
  logic [31:0] cur_sum;
  logic        cur_rdy;
  logic        cur_ov;
  logic        cur_co;
  logic        cur_of;

  int pass_cnt;
  int chk_cnt;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_v[0]), .o_in_ready(rdy[0]),
    .i_a(a_in[15:0]), .i_b(b_in[15:0]), .i_cin(cin), .i_sub(sub),
    .o_out_valid(ov_v[0]), .i_out_ready(out_ready), .o_sum(sum0),
    .o_cout(co_v[0]), .o_ovf(of_v[0]));

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_v[1]), .o_in_ready(rdy[1]),
    .i_a(a_in), .i_b(b_in), .i_cin(cin), .i_sub(sub),
    .o_out_valid(ov_v[1]), .i_out_ready(out_ready), .o_sum(sum1),
    .o_cout(co_v[1]), .o_ovf(of_v[1]));

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_v[2]), .o_in_ready(rdy[2]),
    .i_a(a_in[15:0]), .i_b(b_in[15:0]), .i_cin(cin), .i_sub(sub),
    .o_out_valid(ov_v[2]), .i_out_ready(out_ready), .o_sum(sum2),
    .o_cout(co_v[2]), .o_ovf(of_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cur_sum = {16'd0, sum0};
    cur_rdy = rdy[0];
    cur_ov  = ov_v[0];
    cur_co  = co_v[0];
    cur_of  = of_v[0];
    case (sel)
      1: begin
        cur_sum = sum1; cur_rdy = rdy[1]; cur_ov = ov_v[1]; cur_co = co_v[1]; cur_of = of_v[1];
      end
      2: begin
        cur_sum = {16'd0, sum2}; cur_rdy = rdy[2]; cur_ov = ov_v[2]; cur_co = co_v[2]; cur_of = of_v[2];
      end
      default: begin
      end
    endcase
  end

  // Reference: exact integer a+b+cin or a-b-cin, then reduce.
  function automatic void ref_op(input int w, input longint a, input longint b,
                                 input bit c, input bit sb,
                                 output longint s, output bit co, output bit ov);
    longint m, ua, ub, sa, sbv, eu, es;
    m  = longint'(1) << w;
    ua = a & (m - 1);
    ub = b & (m - 1);
    if (sb) begin
      eu = ua - ub - longint'(c);
      co = (eu >= 0);
    end else begin
      eu = ua + ub + longint'(c);
      co = (eu >= m);
    end
    s   = eu & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    es  = sb ? (sa - sbv - longint'(c)) : (sa + sbv + longint'(c));
    ov  = (es >= m / 2) || (es < -(m / 2));
  endfunction

  task automatic run_op(input int s, input int w, input int lat_exp,
                        input longint a, input longint b, input bit c, input bit sb,
                        input string nm);
    longint es;
    bit ec, eo;
    int lat;
    sel = s;
    ref_op(w, a, b, c, sb, es, ec, eo);
    if (cur_rdy !== 1'b1) begin
      chk_cnt++;
      $display("FAIL %s in_ready before accept: got %b want 1", nm, cur_rdy);
    end
    a_in = a[31:0]; b_in = b[31:0]; cin = c; sub = sb;
    in_v[s] = 1'b1;
    @(posedge clk); #1;
    in_v[s] = 1'b0;
    lat = 0;
    while (!cur_ov && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_cnt++;
    if (lat !== lat_exp) $display("FAIL %s latency: got %0d want %0d", nm, lat, lat_exp);
    else pass_cnt++;
    chk_cnt++;
    if (cur_sum !== es[31:0]) $display("FAIL %s sum: got %h want %h", nm, cur_sum, es[31:0]);
    else pass_cnt++;
    chk_cnt++;
    if (cur_co !== ec) $display("FAIL %s cout: got %b want %b", nm, cur_co, ec);
    else pass_cnt++;
    chk_cnt++;
    if (cur_of !== eo) $display("FAIL %s ovf: got %b want %b", nm, cur_of, eo);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_v = 3'b000; out_ready = 1'b0;
    a_in = 32'd0; b_in = 32'd0; cin = 1'b0; sub = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (rdy !== 3'b111 || ov_v !== 3'b000) $display("FAIL reset handshake: rdy=%b ov=%b want 111/000", rdy, ov_v);
    else pass_cnt++;
    chk_cnt++;
    if (sum0 !== 16'd0 || sum1 !== 32'd0 || sum2 !== 16'd0) $display("FAIL reset sum: got %h %h %h want 0", sum0, sum1, sum2);
    else pass_cnt++;
    chk_cnt++;
    if (co_v !== 3'b000 || of_v !== 3'b000) $display("FAIL reset flags: cout=%b ovf=%b want 000", co_v, of_v);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    run_op(0, 16, 4, 64'hFFFF, 64'h0001, 1'b0, 1'b0, "add_wrap");
    run_op(0, 16, 4, 64'h7FFF, 64'h0001, 1'b0, 1'b0, "signed_ovf");
    run_op(0, 16, 4, 64'h01C0, 64'h00B0, 1'b1, 1'b0, "add_cin");
    run_op(0, 16, 4, 64'h0005, 64'h0007, 1'b0, 1'b1, "sub_neg");
    run_op(0, 16, 4, 64'h0010, 64'h0001, 1'b1, 1'b1, "sub_borrow");
    run_op(0, 16, 4, 64'h8000, 64'h0001, 1'b0, 1'b1, "sub_ovf");
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int lat;
    sel = 0;
    a_in = 32'h1234; b_in = 32'h4321; cin = 1'b0; sub = 1'b0;
    in_v[0] = 1'b1;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    lat = 0;
    while (!cur_ov && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    held = 32'h5555;
    for (int i = 0; i < 5; i++) begin
      in_v[0] = 1'b1;
      a_in = $urandom; b_in = $urandom;
      @(posedge clk); #1;
      chk_cnt++;
      if (cur_ov !== 1'b1 || cur_rdy !== 1'b0) $display("FAIL bp_hold handshake: ov=%b rdy=%b want 1/0", cur_ov, cur_rdy);
      else pass_cnt++;
      chk_cnt++;
      if (cur_sum !== held || cur_co !== 1'b0 || cur_of !== 1'b0) $display("FAIL bp_hold result: sum=%h co=%b of=%b want 5555/0/0", cur_sum, cur_co, cur_of);
      else pass_cnt++;
    end
    in_v[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_cnt++;
    if (cur_ov !== 1'b0 || cur_rdy !== 1'b1) $display("FAIL bp_drain: ov=%b rdy=%b want 0/1", cur_ov, cur_rdy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    sel = 0;
    a_in = 32'hABCD; b_in = 32'h4321; cin = 1'b1; sub = 1'b0;
    in_v[0] = 1'b1;
    @(posedge clk); #1;
    in_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_cnt++;
    if (cur_ov !== 1'b0 || cur_rdy !== 1'b1 || cur_sum !== 32'd0) $display("FAIL abort: ov=%b rdy=%b sum=%h want 0/1/0", cur_ov, cur_rdy, cur_sum);
    else pass_cnt++;
    run_op(0, 16, 4, 64'h1111, 64'h0001, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_params();
    run_op(1, 32, 4, 64'hDDDDDDDD, 64'h00000001, 1'b0, 1'b0, "w32_add");
    run_op(1, 32, 4, 64'h80000000, 64'h00000001, 1'b1, 1'b1, "w32_sub_ovf");
    run_op(2, 16, 1, 64'h7FFF, 64'h7FFF, 1'b1, 1'b0, "w16c16_add");
    run_op(2, 16, 1, 64'h0000, 64'h0000, 1'b1, 1'b1, "w16c16_sub");
  endtask

  task automatic test_random();
    longint a, b;
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom) & 64'hFFFF;
      b = longint'($urandom) & 64'hFFFF;
      run_op(0, 16, 4, a, b, 1'($urandom_range(1)), 1'($urandom_range(1)), "rand16");
    end
    for (int i = 0; i < 100; i++) begin
      a = longint'($urandom);
      b = longint'($urandom);
      run_op(1, 32, 4, a & 64'hFFFFFFFF, b & 64'hFFFFFFFF, 1'($urandom_range(1)), 1'($urandom_range(1)), "rand32");
      run_op(2, 16, 1, a & 64'hFFFF, b & 64'hFFFF, 1'($urandom_range(1)), 1'($urandom_range(1)), "rand16c16");
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_params();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
